// File: rtl/button_pkg.sv
// Shared types and constants for the push-button step counter blocks.
// Contents: FSM state type, default timing constants (27 MHz board clock),
// and width helpers for counters that must hold values 0..N-1.
package button_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StPressed = 2'd1,
    StHeld    = 2'd2
  } state_e;

  localparam int unsigned DefDebounceTime  = 500000;
  localparam int unsigned DefLongPressTime = 13500000;
  localparam int unsigned DefRepeatTime    = 2700000;
  localparam int unsigned CountWidth       = 6;

  // Bits needed for a counter that runs 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Synchronizer plus symmetric debouncer for an active-low push button.
// Ports:
//   clk_i      - system clock
//   rst_i      - asynchronous active-high reset
//   button_i   - raw active-low pin, asynchronous to clk_i
//   press_o    - one-cycle pulse after the debounced level falls (press)
//   release_o  - one-cycle pulse after the debounced level rises (release)
module button_debouncer
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TIME = DefDebounceTime
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic button_i,
  output logic press_o,
  output logic release_o
);

  localparam int unsigned CntW = cnt_width(DEBOUNCE_TIME);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_TIME - 1);

  logic            sync1_q, sync2_q;
  logic            stable_q, stable_d;
  logic            stable_dly_q;
  logic            press_q, release_q;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Count cycles the synchronized level disagrees with the accepted level; any
  // agreement restarts the count, so only an unbroken run is accepted.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CntMax) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      stable_q     <= 1'b1;
      stable_dly_q <= 1'b1;
      cnt_q        <= '0;
      press_q      <= 1'b0;
      release_q    <= 1'b0;
    end else begin
      sync1_q      <= button_i;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      cnt_q        <= cnt_d;
      // Edge pulses are registered so the consumer sees flop-driven events.
      press_q      <= stable_dly_q & ~stable_q;
      release_q    <= ~stable_dly_q & stable_q;
    end
  end

  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/button_step_counter.sv
// Debounced push-button step counter with hold-to-auto-repeat.
// Ports:
//   clk_i    - system clock
//   rst_i    - asynchronous active-high reset
//   button_i - raw active-low button pin
//   count_o  - 6-bit step count (wraps modulo 64)
//   led_o    - active-low LED drive, ~count_o
//   step_o   - one-cycle pulse coincident with each new count value
module button_step_counter
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TIME   = DefDebounceTime,
  parameter int unsigned LONG_PRESS_TIME = DefLongPressTime,
  parameter int unsigned REPEAT_TIME     = DefRepeatTime
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  button_i,
  output logic [CountWidth-1:0] count_o,
  output logic [CountWidth-1:0] led_o,
  output logic                  step_o
);

  localparam int unsigned TmrW = cnt_width(max_u(LONG_PRESS_TIME, REPEAT_TIME));
  localparam logic [TmrW-1:0] LongMax = TmrW'(LONG_PRESS_TIME - 1);
  localparam logic [TmrW-1:0] RepMax  = TmrW'(REPEAT_TIME - 1);

  logic                  press, release_evt;
  state_e                state_q, state_d;
  logic [TmrW-1:0]       tmr_q, tmr_d;
  logic [CountWidth-1:0] count_q, count_d;
  logic                  step_q, step_d;

  button_debouncer #(
    .DEBOUNCE_TIME(DEBOUNCE_TIME)
  ) u_debouncer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .button_i (button_i),
    .press_o  (press),
    .release_o(release_evt)
  );

  // One timer serves both the long-press wait and the repeat interval; it is
  // cleared on every state change. Release always wins over a timer expiry.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q + 1'b1;
    count_d = count_q;
    step_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        tmr_d = '0;
        if (press) begin
          state_d = StPressed;
          count_d = count_q + 1'b1;
          step_d  = 1'b1;
        end
      end
      StPressed: begin
        if (release_evt) begin
          state_d = StIdle;
          tmr_d   = '0;
        end else if (tmr_q == LongMax) begin
          state_d = StHeld;
          tmr_d   = '0;
          count_d = count_q + 1'b1;
          step_d  = 1'b1;
        end
      end
      StHeld: begin
        if (release_evt) begin
          state_d = StIdle;
          tmr_d   = '0;
        end else if (tmr_q == RepMax) begin
          tmr_d   = '0;
          count_d = count_q + 1'b1;
          step_d  = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        tmr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      tmr_q   <= '0;
      count_q <= '0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      count_q <= count_d;
      step_q  <= step_d;
    end
  end

  assign count_o = count_q;
  assign led_o   = ~count_q;
  assign step_o  = step_q;

endmodule

// File: tb/tb_button_step_counter.sv
// Scoreboard bench for button_step_counter. The driver issues button samples
// and a timing-rule model pushes expected steps (edge number, count); a
// monitor pops and compares whenever the DUT pulses step.
module tb_button_step_counter;

  localparam int unsigned D = 4;
  localparam int unsigned L = 20;
  localparam int unsigned R = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       button = 1'b1;
  logic [5:0] count, led;
  logic       step;

  button_step_counter #(
    .DEBOUNCE_TIME  (D),
    .LONG_PRESS_TIME(L),
    .REPEAT_TIME    (R)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .button_i(button),
    .count_o (count),
    .led_o   (led),
    .step_o  (step)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {int e; logic [5:0] cnt;} exp_t;
  typedef struct {int e; bit press;} ev_t;
  exp_t expq[$];
  ev_t  evq[$];

  // Model: a level is accepted after D consecutive samples of it, and the FSM
  // reacts 4 edges after the last of those samples (D+3 after the first).
  logic       m_acc;
  int         m_run;
  bit         m_pressed;
  int         m_next;
  logic [5:0] m_count;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_acc = 1'b1;
    m_run = 0;
    m_pressed = 0;
    m_next = 0;
    m_count = '0;
    evq.delete();
  endtask

  task automatic model_edge(input logic b, input int e);
    bit prs, rel;
    prs = 0;
    rel = 0;
    if (b != m_acc) begin
      m_run++;
      if (m_run >= int'(D)) begin
        m_acc = b;
        m_run = 0;
        evq.push_back('{e + 4, !b});
      end
    end else begin
      m_run = 0;
    end
    while (evq.size() != 0 && evq[0].e == e) begin
      if (evq[0].press) prs = 1;
      else rel = 1;
      void'(evq.pop_front());
    end
    if (rel) begin
      m_pressed = 0;
    end else if (prs && !m_pressed) begin
      m_count++;
      m_pressed = 1;
      m_next = e + int'(L);
      expq.push_back('{e, m_count});
    end else if (m_pressed && e == m_next) begin
      m_count++;
      m_next = e + int'(R);
      expq.push_back('{e, m_count});
    end
  endtask

  task automatic drive(input logic b);
    @(negedge clk);
    button = b;
    model_edge(b, cyc + 1);
  endtask

  task automatic hold(input logic b, input int n);
    repeat (n) drive(b);
  endtask

  task automatic do_reset(input int n, input logic b);
    @(negedge clk);
    rst = 1'b1;
    button = b;
    #1;
    check("rst_count", count, 0);
    check("rst_led", led, 6'h3F);
    check("rst_step", step, 0);
    model_reset();
    expq.delete();
    repeat (n) @(negedge clk);
    rst = 1'b0;
    model_edge(b, cyc + 1);
  endtask

  // Monitor
  initial begin
    exp_t x;
    logic [5:0] nled;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() != 0 && expq[0].e < cyc) begin
        checks++;
        failures++;
        $display("FAIL missing_step: none at edge %0d, required count %0d", expq[0].e,
                 expq[0].cnt);
        void'(expq.pop_front());
      end
      if (step) begin
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_step: step at edge %0d count %0d, required none", cyc,
                   count);
        end else begin
          x = expq.pop_front();
          nled = ~x.cnt;
          check("step_edge", cyc, x.e);
          check("step_count", count, x.cnt);
          check("step_led", led, nled);
        end
      end
    end
  end

  initial begin
    logic lvl;
    model_reset();

    // Reset and idle stability.
    do_reset(3, 1'b1);
    hold(1'b1, 50);
    check("idle_count", count, 0);
    check("idle_led", led, 6'h3F);

    // Glitch one cycle shorter than the debounce window.
    hold(1'b0, 3);
    hold(1'b1, 20);
    check("glitch_count", count, 0);

    // Single short press.
    hold(1'b0, 10);
    hold(1'b1, 20);
    check("short_count", count, 1);
    check("short_led", led, 6'h3E);

    // Long press; release coincides with a repeat expiry and must win.
    do_reset(2, 1'b1);
    hold(1'b0, 60);
    hold(1'b1, 20);
    check("long_count", count, 6);

    // Wrap from 63 to 0.
    do_reset(2, 1'b1);
    repeat (63) begin
      hold(1'b0, 6);
      hold(1'b1, 6);
    end
    check("preload_count", count, 63);
    hold(1'b0, 6);
    hold(1'b1, 8);
    check("wrap_count", count, 0);
    check("wrap_led", led, 6'h3F);

    // Reset while auto-repeating, button kept low throughout.
    do_reset(2, 1'b1);
    hold(1'b0, 55);
    check("held_count", count, 5);
    do_reset(2, 1'b0);
    hold(1'b0, 10);
    check("post_rst_count", count, 1);
    hold(1'b1, 20);

    // Randomized segments with occasional resets.
    lvl = 1'b1;
    repeat (150) begin
      lvl = ~lvl;
      if ($urandom_range(0, 19) == 0) begin
        do_reset(int'($urandom_range(1, 3)), lvl);
      end
      if ($urandom_range(0, 3) == 0) hold(lvl, int'($urandom_range(1, D + 1)));
      else hold(lvl, int'($urandom_range(1, 70)));
    end

    hold(1'b1, 30);
    check("final_count", count, m_count);
    check("queue_drained", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
